wb_sram_slave_b3: RTL and testbench

- Wishbone B3 responder: a single-port on-chip SRAM that sits behind one slave port of the bus expander and answers cycles from the bus masters.
- Supports classic single cycles, programmable wait states, and incrementing-address bursts (cti=010).
- Signals an address-range error.

---
 rtl/wb_sram_slave_b3_if.sv | 26 ++
 rtl/wb_sram_slave_b3.sv | 135 +++++++++++++
 tb/tb_wb_sram_slave_b3.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_slave_b3_if.sv
// Wishbone B3 signal bundle used between the bus expander and its slave ports.
// The slave modport is what wb_sram_slave_b3 connects to.
interface wb_sram_slave_b3_if;
  logic [31:0] adr;
  logic        cyc;
  logic [31:0] dat_m2s;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_s2m;
  logic        ack;
  logic        err;
  logic        rty;

  modport slave (
    input  adr, cyc, dat_m2s, sel, we, stb, cti, bte,
    output dat_s2m, ack, err, rty
  );

  modport master (
    output adr, cyc, dat_m2s, sel, we, stb, cti, bte,
    input  dat_s2m, ack, err, rty
  );
endinterface

// File: rtl/wb_sram_slave_b3.sv
// Wishbone B3 single-port SRAM slave with programmable wait states and range error.
// Define WB_SRAM_BURST_EN to enable incrementing bursts (cti=010) at one beat per cycle.
module wb_sram_slave_b3 #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic               clk,
  input logic               rst,
  wb_sram_slave_b3_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef WB_SRAM_BURST_EN
  localparam logic [AW:0] CNT_END  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [2:0]  CTI_INCR = 3'b010;
  localparam logic [2:0]  CTI_EOB  = 3'b111;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, XFER, BURST} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   cnt, cnt_nxt;          // word index; one extra bit to reach DEPTH
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic          err_q, err_nxt;
  logic [31:0]   rdata;
  logic [31:0]   mem [DEPTH];
  logic          req, ack, err, wr_en;
  logic [32:0]   off;                   // bit 32 is the borrow: adr below BASE_ADDR
  logic          out_of_range;

  assign req          = bus.cyc & bus.stb;
  assign off          = {1'b0, bus.adr} - {1'b0, BASE_ADDR};
  assign out_of_range = off[32] | (off[31:2] >= DEPTH_W);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_q;
    ack          = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt = {1'b0, off[AW+1:2]};
          err_nxt = out_of_range;
          if (out_of_range || WAIT_STATES == 0) begin
            state_nxt = XFER;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_nxt    = XFER;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      XFER: begin
        if (req) begin
          ack       = ~err_q;
          err       = err_q;
          state_nxt = IDLE;
`ifdef WB_SRAM_BURST_EN
          if (!err_q && bus.cti == CTI_INCR) begin
            state_nxt = BURST;
            cnt_nxt   = cnt + CNT_ONE;
          end
`endif
        end
      end
`ifdef WB_SRAM_BURST_EN
      BURST: begin
        if (req) begin
          if (cnt == CNT_END) begin
            err       = 1'b1;
            state_nxt = IDLE;
          end else begin
            ack     = 1'b1;
            cnt_nxt = cnt + CNT_ONE;
            if (bus.cti == CTI_EOB) state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (!bus.cyc) state_nxt = IDLE;
  end

  // A beat whose ack edge coincides with reset is dropped.
  assign wr_en = ack & bus.we & ~rst;

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with <= so every process sees pre-edge values regardless of evaluation order.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wait_cnt <= 4'd0;
      err_q    <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_nxt;
      // Read the next beat's word now so back-to-back acks carry data with no bubble.
      rdata    <= mem[cnt_nxt[AW-1:0]];
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn the block RAM into a register file.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sel[i]) mem[cnt[AW-1:0]][8*i +: 8] <= bus.dat_m2s[8*i +: 8];
      end
    end
  end

  assign bus.ack     = ack;
  assign bus.err     = err;
  assign bus.rty     = 1'b0;
  assign bus.dat_s2m = ack ? rdata : 32'h0;

  // Byte offset, bte and (without bursts) cti plus the counter's top bit are intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, off[1:0], bus.bte, bus.cti, cnt[AW]};

endmodule

// File: tb/tb_wb_sram_slave_b3.sv
// Directed bench: three slaves (BASE 0x1000/WS1, BASE 0/WS0, BASE 0/WS3) share one master;
// sel_dut picks which one sees cyc and whose outputs are observed.
module tb_wb_sram_slave_b3;

  localparam logic [31:0] BASE0 = 32'h0000_1000;
  localparam int          D     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic [2:0]  m_cti;
  int          sel_dut = 0;

  logic        ack_v [3];
  logic        err_v [3];
  logic        rty_v [3];
  logic [31:0] dat_v [3];
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;

  int checks = 0;
  int errors = 0;

  wb_sram_slave_b3_if bi [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bi[g].adr     = m_adr;
    assign bi[g].cyc     = m_cyc && (sel_dut == g);
    assign bi[g].dat_m2s = m_dat;
    assign bi[g].sel     = m_sel;
    assign bi[g].we      = m_we;
    assign bi[g].stb     = m_stb;
    assign bi[g].cti     = m_cti;
    assign bi[g].bte     = 2'b00;
    assign ack_v[g]      = bi[g].ack;
    assign err_v[g]      = bi[g].err;
    assign rty_v[g]      = bi[g].rty;
    assign dat_v[g]      = bi[g].dat_s2m;

    wb_sram_slave_b3 #(
      .DEPTH       (D),
      .BASE_ADDR   (g == 0 ? BASE0 : 32'h0),
      .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bi[g])
    );
  end

  assign s_ack = ack_v[sel_dut];
  assign s_err = err_v[sel_dut];
  assign s_rty = rty_v[sel_dut];
  assign s_dat = dat_v[sel_dut];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_bus();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_cti = 3'b000;
  endtask

  // One classic transfer; lat = cycles from first request cycle to the ack/err cycle (20 max).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic ack_o,
                      output logic err_o, output int lat);
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_adr = a; m_dat = d; m_sel = s; m_cti = 3'b000;
    lat = 0;
    #1;
    while (!(s_ack || s_err) && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    rd = s_dat; ack_o = s_ack; err_o = s_err;
    @(negedge clk);
    idle_bus();
  endtask

  logic [31:0] bdat [8];
  logic        back [8];
  logic        berr [8];
  int          bcyc [8];
  logic        pause_ack, post_ack, post_err;

  // Read burst of n beats from word start; stb drops for two cycles after beat pause_after.
  task automatic burst(input int start, input int n, input bit eob, input int pause_after);
    int t, w;
    t = 0;
    pause_ack = 1'b0;
    @(negedge clk);
    m_cyc = 1'b1; m_we = 1'b0; m_sel = 4'hF;
    for (int i = 0; i < n; i++) begin
      m_stb = 1'b1;
      m_adr = 32'(4 * (start + i));
      m_cti = (eob && i == n - 1) ? 3'b111 : 3'b010;
      w = 0;
      #1;
      while (!(s_ack || s_err) && w < 20) begin
        @(negedge clk); #1; t++; w++;
      end
      bdat[i] = s_dat; back[i] = s_ack; berr[i] = s_err; bcyc[i] = t;
      @(negedge clk); t++;
      if (i == pause_after) begin
        m_stb = 1'b0;
        #1 pause_ack = pause_ack | s_ack;
        @(negedge clk); t++;
        #1 pause_ack = pause_ack | s_ack;
        @(negedge clk); t++;
      end
    end
    m_stb = 1'b1;
    m_adr = 32'(4 * (start + n));
    m_cti = 3'b000;
    #1 post_ack = s_ack; post_err = s_err;
    @(negedge clk);
    idle_bus();
  endtask

  logic [31:0] rd;
  logic        a, e;
  int          lat;

  initial begin
    rst = 1'b1;
    idle_bus();
    m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state on two slaves
    #1;
    check("rst_ack0", {31'h0, s_ack}, 32'h0);
    check("rst_err0", {31'h0, s_err}, 32'h0);
    check("rst_dat0", s_dat, 32'h0);
    sel_dut = 1;
    #1;
    check("rst_ack1", {31'h0, s_ack}, 32'h0);
    check("rst_rty1", {31'h0, s_rty}, 32'h0);

    // Slave 0: BASE 0x1000, WAIT_STATES=1
    sel_dut = 0;
    xfer(1'b1, BASE0, 32'hC0DE_0000, 4'hF, rd, a, e, lat);
    xfer(1'b1, BASE0 + 32'h10, 32'hDEAD_BEEF, 4'hF, rd, a, e, lat);
    check("wr_ack", {31'h0, a}, 32'h1);
    check("wr_lat", 32'(lat), 32'd2);
    xfer(1'b0, BASE0 + 32'h10, 32'h0, 4'hF, rd, a, e, lat);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_err", {31'h0, e}, 32'h0);
    check("rd_rty", {31'h0, s_rty}, 32'h0);

    xfer(1'b1, BASE0 + 32'h14, 32'h1122_3344, 4'hF, rd, a, e, lat);
    xfer(1'b1, BASE0 + 32'h17, 32'h0000_00AA, 4'b0001, rd, a, e, lat);
    xfer(1'b0, BASE0 + 32'h14, 32'h0, 4'hF, rd, a, e, lat);
    check("byte_lane", rd, 32'h1122_33AA);

    xfer(1'b0, BASE0 + 32'h40, 32'h0, 4'hF, rd, a, e, lat);
    check("oor_hi_err", {31'h0, e}, 32'h1);
    check("oor_hi_ack", {31'h0, a}, 32'h0);
    check("oor_hi_dat", rd, 32'h0);
    check("oor_hi_lat", 32'(lat), 32'd1);
    xfer(1'b0, BASE0 - 32'h4, 32'h0, 4'hF, rd, a, e, lat);
    check("oor_lo_err", {31'h0, e}, 32'h1);
    check("oor_lo_ack", {31'h0, a}, 32'h0);
    xfer(1'b1, BASE0 + 32'h40, 32'hFFFF_FFFF, 4'hF, rd, a, e, lat);
    check("oor_wr_err", {31'h0, e}, 32'h1);
    xfer(1'b0, BASE0, 32'h0, 4'hF, rd, a, e, lat);
    check("oor_ram_keep", rd, 32'hC0DE_0000);

    // Slave 1: BASE 0, WAIT_STATES=0
    sel_dut = 1;
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'(4 * i), 32'(i + 1), 4'hF, rd, a, e, lat);
    xfer(1'b1, 32'(4 * (D - 2)), 32'h0000_00EE, 4'hF, rd, a, e, lat);
    xfer(1'b1, 32'(4 * (D - 1)), 32'h0000_00FF, 4'hF, rd, a, e, lat);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, a, e, lat);
    check("ws0_lat", 32'(lat), 32'd1);

    burst(0, 4, 1'b1, -1);
    for (int i = 0; i < 4; i++) check($sformatf("b4_dat%0d", i), bdat[i], 32'(i + 1));
    check("b4_post_ack", {31'h0, post_ack}, 32'h0);
`ifdef WB_SRAM_BURST_EN
    check("b4_last_cyc", 32'(bcyc[3]), 32'd4);
`else
    check("b4_last_cyc", 32'(bcyc[3]), 32'd7);
`endif

    burst(0, 4, 1'b1, 1);
    check("bp_pause_ack", {31'h0, pause_ack}, 32'h0);
    check("bp_dat2", bdat[2], 32'd3);
    check("bp_dat3", bdat[3], 32'd4);
`ifdef WB_SRAM_BURST_EN
    check("bp_last_cyc", 32'(bcyc[3]), 32'd6);
`else
    check("bp_last_cyc", 32'(bcyc[3]), 32'd9);
`endif

    burst(D - 2, 3, 1'b0, -1);
    check("bend_dat0", bdat[0], 32'h0000_00EE);
    check("bend_dat1", bdat[1], 32'h0000_00FF);
    check("bend_ack2", {31'h0, back[2]}, 32'h0);
    check("bend_err2", {31'h0, berr[2]}, 32'h1);
    check("bend_dat2", bdat[2], 32'h0);
    check("bend_idle_ack", {31'h0, post_ack}, 32'h0);
    check("bend_idle_err", {31'h0, post_err}, 32'h0);

    // Reset in the middle of a write burst: beat 0 lands, beat 1 does not
    xfer(1'b1, 32'h24, 32'h9999_0009, 4'hF, rd, a, e, lat);
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF;
    m_adr = 32'h20; m_dat = 32'hAAAA_0008; m_cti = 3'b010;
    @(negedge clk); #1;
    check("rstb_beat0_ack", {31'h0, s_ack}, 32'h1);
    @(negedge clk);
    m_adr = 32'h24; m_dat = 32'hBBBB_0009; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    #1;
    check("rstb_ack", {31'h0, s_ack}, 32'h0);
    check("rstb_err", {31'h0, s_err}, 32'h0);
    check("rstb_dat", s_dat, 32'h0);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, a, e, lat);
    check("rstb_word8", rd, 32'hAAAA_0008);
    xfer(1'b0, 32'h24, 32'h0, 4'hF, rd, a, e, lat);
    check("rstb_word9", rd, 32'h9999_0009);

    // Slave 2: WAIT_STATES=3, cyc dropped while waiting
    sel_dut = 2;
    xfer(1'b1, 32'h14, 32'h5555_0005, 4'hF, rd, a, e, lat);
    check("ws3_lat", 32'(lat), 32'd4);
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF;
    m_adr = 32'h14; m_dat = 32'hBAD0_BAD0; m_cti = 3'b000;
    #1 check("drop_ack_c0", {31'h0, s_ack}, 32'h0);
    @(negedge clk);
    #1 check("drop_ack_c1", {31'h0, s_ack}, 32'h0);
    @(negedge clk);
    idle_bus();
    #1 check("drop_ack_c2", {31'h0, s_ack}, 32'h0);
    @(negedge clk);
    #1;
    check("drop_out_ack", {31'h0, s_ack}, 32'h0);
    check("drop_out_err", {31'h0, s_err}, 32'h0);
    check("drop_out_dat", s_dat, 32'h0);
    xfer(1'b0, 32'h14, 32'h0, 4'hF, rd, a, e, lat);
    check("drop_word_keep", rd, 32'h5555_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
